// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: funct3 size/sign codes,
// FSM state encoding, the latched request record and lane helper functions.
package mem_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        rd;
    logic        wr;
  } req_t;

  // Legal size/sign code for the direction, and naturally aligned for its size.
  function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] a,
                                        input logic is_store);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !is_store;
      F3_H:    ok = !a[0];
      F3_HU:   ok = !is_store && !a[0];
      F3_W:    ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/halfword lane out of a read word and sign- or
// zero-extends it according to funct3; word loads pass straight through.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [15:0] lane;

  always_comb begin
    lane = 16'(rdata >> {addr, 3'b000});
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   data = {24'b0, lane[7:0]};
      F3_H:    data = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   data = {16'b0, lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: latches one request from the controller, runs the
// data-memory handshake with a timeout guard, and reports done/fault.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [31:0]        load_data,
  mem_access_unit_if.master  dmem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  req_t               req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic [31:0]        load_data_q, load_data_d;
  logic [31:0]        aligned_data;
  logic               in_req;
  logic               timeout_hit;

  load_align u_load_align (
    .rdata  (dmem.dmem_rdata),
    .addr   (req_q.addr[1:0]),
    .funct3 (req_q.funct3),
    .data   (aligned_data)
  );

  assign in_req      = (state_q == ST_REQ);
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    load_data_d = load_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          req_d.addr   = addr;
          req_d.wdata  = store_data;
          req_d.funct3 = funct3;
          req_d.rd     = mem_read;
          req_d.wr     = mem_write;
          cnt_d        = '0;
          fault_d      = 1'b0;
          if (!mem_read && !mem_write) begin
            state_d = ST_DONE;
          end else if ((mem_read && mem_write) ||
                       !access_legal(funct3, addr[1:0], mem_write)) begin
            state_d = ST_DONE;
            fault_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end

      // A grant completes a store outright; a load still has to wait for rvalid.
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.dmem_gnt && req_q.wr) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          fault_d = 1'b1;
        end else if (dmem.dmem_gnt) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.dmem_rvalid) begin
          load_data_d = aligned_data;
          state_d     = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          fault_d = 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign fault     = fault_q;
  assign load_data = load_data_q;

  // Write strobes only appear while a store is actually on the bus.
  assign dmem.dmem_req   = in_req;
  assign dmem.dmem_we    = in_req && req_q.wr;
  assign dmem.dmem_be    = (in_req && req_q.wr) ? byte_enable(req_q.funct3, req_q.addr[1:0])
                                                : 4'b0000;
  assign dmem.dmem_addr  = {req_q.addr[31:2], 2'b00};
  assign dmem.dmem_wdata = store_lanes(req_q.funct3, req_q.wdata);

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of cycles spent in REQ+RESP before the access is aborted with fault.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request from the sequential controller; operands valid in the same cycle.
REQ-005 mem_read  in  1  operation is a load.
REQ-006 mem_write  in  1  operation is a store.
REQ-007 funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu; stores use 000/001/010 only.
REQ-008 addr  in  32  byte address, equal to the Execute ALU_result.
REQ-009 store_data  in  32  store source, equal to Execute read_data2.
REQ-010 busy  out  1  high from the cycle after start is accepted until done.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 fault  out  1  valid with done; misaligned, illegal or timed-out access.
REQ-013 load_data  out  32  extended load result, held until the next accepted start.
REQ-014 dmem_req  out  1  memory request, held until dmem_gnt.
REQ-015 dmem_we  out  1  write enable, valid with dmem_req.
REQ-016 dmem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-017 dmem_be  out  4  byte enables.
REQ-018 dmem_wdata  out  32  lane-replicated store data.
REQ-019 dmem_gnt  in  1  memory accepted the request.
REQ-020 dmem_rvalid  in  1  read data valid.
REQ-021 dmem_rdata  in  32  read data word.

Function
REQ-022 FSM states: IDLE, REQ, RESP, DONE; DONE lasts exactly one cycle and returns to IDLE.
REQ-023 start is accepted only in IDLE; start in any other state is ignored.
REQ-024 On acceptance, addr, store_data, funct3, mem_read and mem_write are registered; later input changes have no effect.
REQ-025 An accepted start with neither mem_read nor mem_write goes to DONE with fault=0, no dmem_req, and load_data unchanged.
REQ-026 An accepted start with both mem_read and mem_write, an illegal funct3, halfword with addr[0]=1, or word with addr[1:0]!=0 goes to DONE with fault=1 and issues no dmem_req.
REQ-027 Legal access: IDLE->REQ; dmem_req=1 throughout REQ; dmem_gnt in REQ moves a store to DONE and a load to RESP.
REQ-028 dmem_rvalid is sampled only in RESP; the first rvalid captures load_data and moves to DONE.
REQ-029 Minimum latency, with start in cycle 0: store done=1 in cycle 2; load done=1 in cycle 3.
REQ-030 Byte enables: b = 4'b0001<<addr[1:0]; h = 4'b0011<<addr[1:0]; w = 4'b1111; dmem_be=0 for loads.
REQ-031 Store data: sb writes {4{store_data[7:0]}}; sh writes {2{store_data[15:0]}}; sw writes store_data.
REQ-032 Load extraction selects the byte or halfword lane by addr[1:0]; b/h are sign-extended, bu/hu are zero-extended, w is passed through.
REQ-033 A timeout counter clears on acceptance and increments each cycle in REQ or RESP; reaching TIMEOUT_CYCLES forces DONE with fault=1, drops dmem_req and leaves load_data unchanged.
REQ-034 fault is cleared on the next accepted start; done is 0 outside DONE.

Reset
REQ-035 rst_n low, asynchronously at any time (including mid-access), forces IDLE and drives busy, done, fault, dmem_req, dmem_we and dmem_be to 0, load_data, dmem_addr and dmem_wdata to 0, and the timeout counter to 0.
REQ-036 A transaction interrupted by reset is abandoned; a late dmem_gnt or dmem_rvalid after reset is ignored in IDLE.

Structure
REQ-037 Shared package mem_pkg holds the funct3 load/store encodings, the FSM state enumeration and the default TIMEOUT_CYCLES.
REQ-038 The combinational lane-select/extension logic is a separate sub-module, load_align (inputs rdata, addr[1:0], funct3; output 32-bit data).

Verification
REQ-039 Load lb, addr=0x103, rdata=0x80FF_1234, gnt in cycle 1, rvalid in cycle 2 -> done in cycle 3, load_data=0xFFFF_FF80, fault=0.
REQ-040 Store sh, addr=0x202, store_data=0x1234_ABCD -> dmem_addr=0x200, dmem_be=4'b1100, dmem_wdata=0xABCD_ABCD, done in cycle 2.
REQ-041 Load lw, addr=0x6 -> done in cycle 1 with fault=1 and no dmem_req at any cycle.
REQ-042 TIMEOUT_CYCLES=4, lw with no gnt -> dmem_req high for 4 cycles, then done=1, fault=1, load_data unchanged.
REQ-043 rst_n asserted in RESP of lhu, then released -> all outputs 0 immediately; a later rvalid produces no done; the next lhu addr=0x2, rdata=0xF00D_0000 gives load_data=0x0000_F00D.
